// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  // Arbiter FSM: IDLE arbitrates, ACC performs the single memory access.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam int WORD_W = 32;
  localparam int STAT_W = 16;

  // Owner encoding, also the index of the winning request bit.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// A lone request always wins; on a tie the port equal to prio wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       valid,
  output logic       winner
);

  // Pick the winner from the request pair and the priority pointer.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = prio;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word data memory.
// Port 0 is the CPU load/store path, port 1 the loader/debug master.
// Each grant latches the transaction, performs one access in ACC, then
// returns to IDLE, so one access completes every two cycles.
//
// Handshake: a requester raises mN_req with we/addr/wdata stable and keeps
// them stable until mN_ack; mN_ack is a one-cycle pulse with mN_rdata and
// mN_err valid in that same cycle. Holding req after ack issues a new
// transaction that is arbitrated in the following IDLE cycle.
//
// Optional build macro DMEM_ARB_STATS_EN adds saturating grant and
// conflict counters (gnt0_cnt, gnt1_cnt, conflict_cnt).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0] gnt0_cnt,
  output logic [15:0] gnt1_cnt,
  output logic [15:0] conflict_cnt,
`endif
  output logic        dbg_state,
  output logic        dbg_prio
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q;
  state_e            state_d;
  logic              prio_q;
  logic              own_q;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              pick_valid;
  logic              pick_winner;
  logic              grant;
  logic              err;
  logic              live_acc;

  rr_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .prio   (prio_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign grant = (state_q == IDLE) && pick_valid;

  // Misaligned or beyond the memory's word range.
  assign err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

  // An ACC cycle only takes effect while reset is released.
  assign live_acc = (state_q == ACC) && rst_n;

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the winning transaction and hand priority to the other port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q  <= PORT_CPU;
      own_q   <= PORT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      own_q   <= pick_winner;
      we_q    <= pick_winner ? m1_we    : m0_we;
      addr_q  <= pick_winner ? m1_addr  : m0_addr;
      wdata_q <= pick_winner ? m1_wdata : m0_wdata;
      prio_q  <= ~pick_winner;
    end
  end

  // Next state plus the per-port completion and memory strobe.
  always_comb begin
    state_d  = state_q;
    m0_ack   = 1'b0;
    m0_rdata = '0;
    m0_err   = 1'b0;
    m1_ack   = 1'b0;
    m1_rdata = '0;
    m1_err   = 1'b0;
    mem_w_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACC;
        end
      end
      ACC: begin
        state_d = IDLE;
        if (live_acc) begin
          mem_w_en = we_q && !err;
          if (own_q == PORT_CPU) begin
            m0_ack   = 1'b1;
            m0_err   = err;
            m0_rdata = err ? '0 : mem_rdata;
          end else begin
            m1_ack   = 1'b1;
            m1_err   = err;
            m1_rdata = err ? '0 : mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] gnt0_q;
  logic [STAT_W-1:0] gnt1_q;
  logic [STAT_W-1:0] conflict_q;

  // Saturating counters of grants per port and of contended IDLE cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0_q     <= '0;
      gnt1_q     <= '0;
      conflict_q <= '0;
    end else begin
      if ((state_q == ACC) && (own_q == PORT_CPU) && (gnt0_q != '1)) begin
        gnt0_q <= gnt0_q + STAT_W'(1);
      end
      if ((state_q == ACC) && (own_q == PORT_DBG) && (gnt1_q != '1)) begin
        gnt1_q <= gnt1_q + STAT_W'(1);
      end
      if ((state_q == IDLE) && m0_req && m1_req && (conflict_q != '1)) begin
        conflict_q <= conflict_q + STAT_W'(1);
      end
    end
  end

  assign gnt0_cnt     = gnt0_q;
  assign gnt1_cnt     = gnt1_q;
  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_w_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        dbg_state, dbg_prio;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt, conflict_cnt;
`endif

  logic [31:0] mem [256];

  int n_cmp;
  int n_bad;

  dmem_arbiter #(.DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_w_en  (mem_w_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
`ifdef DMEM_ARB_STATS_EN
    .gnt0_cnt     (gnt0_cnt),
    .gnt1_cnt     (gnt1_cnt),
    .conflict_cnt (conflict_cnt),
`endif
    .dbg_state (dbg_state),
    .dbg_prio  (dbg_prio)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the rising edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr[9:2]] <= mem_wdata;
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_wen;
    logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port == 1'b0) begin
      m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;

    // index 4 old value, then reload
    vecs[0] = '{0, 1, 32'h10,  32'hDEADBEEF, 0, 32'hA5000004, 1, 32'h10};
    vecs[1] = '{0, 0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 0, 32'h10};
    vecs[2] = '{1, 0, 32'h20,  32'h0,        0, 32'hA5000008, 0, 32'h20};
    vecs[3] = '{1, 1, 32'h3FC, 32'h12345678, 0, 32'hA50000FF, 1, 32'h3FC};
    vecs[4] = '{0, 0, 32'h3FC, 32'h0,        0, 32'h12345678, 0, 32'h3FC};
    vecs[5] = '{0, 1, 32'h402, 32'h11111111, 1, 32'h0,        0, 32'h400};
    vecs[6] = '{0, 1, 32'h400, 32'h22222222, 1, 32'h0,        0, 32'h400};
    vecs[7] = '{1, 0, 32'h401, 32'h0,        1, 32'h0,        0, 32'h400};
    vecs[8] = '{0, 0, 32'h400, 32'h0,        1, 32'h0,        0, 32'h400};
    vecs[9] = '{0, 0, 32'h0,   32'h0,        0, 32'hA5000000, 0, 32'h0};

    // Reset block
    rst_n = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst_ack0", {31'b0, m0_ack}, 0);
    check("rst_ack1", {31'b0, m1_ack}, 0);
    check("rst_wen", {31'b0, mem_w_en}, 0);
    check("rst_state", {31'b0, dbg_state}, 0);
    check("rst_prio", {31'b0, dbg_prio}, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_rdata0", m0_rdata, 0);

    // Both ports held from reset: 0,1,0,1,0 with an IDLE cycle between acks.
    drive(0, 0, 32'h04, 0);
    drive(1, 0, 32'h08, 0);
    rst_n = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("both_ack0_k%0d", k), {31'b0, m0_ack}, {31'b0, (k % 4) == 1});
      check($sformatf("both_ack1_k%0d", k), {31'b0, m1_ack}, {31'b0, (k % 4) == 3});
      check($sformatf("both_prio_k%0d", k), {31'b0, dbg_prio}, {31'b0, (k % 4) == 1 || (k % 4) == 2});
      if ((k % 4) == 1) check($sformatf("both_rd0_k%0d", k), m0_rdata, 32'hA5000001);
      if ((k % 4) == 3) check($sformatf("both_rd1_k%0d", k), m1_rdata, 32'hA5000002);
    end
    idle_inputs();
`ifdef DMEM_ARB_STATS_EN
    check("stat_conflict", {16'b0, conflict_cnt}, 5);
    check("stat_gnt0", {16'b0, gnt0_cnt}, 3);
    check("stat_gnt1", {16'b0, gnt1_cnt}, 2);
`endif

    // Table-driven single transactions
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      @(negedge clk);
      if (vecs[v].port == 1'b0) begin
        check($sformatf("v%0d_ack", v), {31'b0, m0_ack}, 1);
        check($sformatf("v%0d_other_ack", v), {31'b0, m1_ack}, 0);
        check($sformatf("v%0d_rdata", v), m0_rdata, vecs[v].exp_rdata);
        check($sformatf("v%0d_err", v), {31'b0, m0_err}, {31'b0, vecs[v].exp_err});
        check($sformatf("v%0d_other_err", v), {31'b0, m1_err}, 0);
      end else begin
        check($sformatf("v%0d_ack", v), {31'b0, m1_ack}, 1);
        check($sformatf("v%0d_other_ack", v), {31'b0, m0_ack}, 0);
        check($sformatf("v%0d_rdata", v), m1_rdata, vecs[v].exp_rdata);
        check($sformatf("v%0d_err", v), {31'b0, m1_err}, {31'b0, vecs[v].exp_err});
        check($sformatf("v%0d_other_err", v), {31'b0, m0_err}, 0);
      end
      check($sformatf("v%0d_wen", v), {31'b0, mem_w_en}, {31'b0, vecs[v].exp_wen});
      check($sformatf("v%0d_maddr", v), mem_addr, vecs[v].exp_maddr);
      idle_inputs();
      @(negedge clk);
      check($sformatf("v%0d_ack_drop", v), {30'b0, m1_ack, m0_ack}, 0);
      check($sformatf("v%0d_wen_idle", v), {31'b0, mem_w_en}, 0);
      check($sformatf("v%0d_maddr_hold", v), mem_addr, vecs[v].exp_maddr);
    end
    check("mem_idx0_untouched", mem[0], 32'hA5000000);

    // Port 1 alone, req held: ack every second cycle, port 0 silent.
    drive(1, 0, 32'h24, 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("p1_ack_k%0d", k), {31'b0, m1_ack}, {31'b0, (k % 2) == 1});
      check($sformatf("p1_ack0_k%0d", k), {31'b0, m0_ack}, 0);
      if ((k % 2) == 1) check($sformatf("p1_rd_k%0d", k), m1_rdata, 32'hA5000009);
    end
    idle_inputs();

    // Reset asserted during the ACC cycle of a store.
    drive(0, 1, 32'h40, 32'hCAFEF00D);
    @(negedge clk);
    check("rstacc_state", {31'b0, dbg_state}, 1);
    check("rstacc_prio", {31'b0, dbg_prio}, 1);
    rst_n = 0;
    #1;
    check("rstacc_wen", {31'b0, mem_w_en}, 0);
    check("rstacc_ack", {31'b0, m0_ack}, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    check("rstacc_idle", {31'b0, dbg_state}, 0);
    check("rstacc_prio0", {31'b0, dbg_prio}, 0);
    check("rstacc_mem", mem[16], 32'hA5000010);
    @(negedge clk);
    check("rstacc_no_ack", {30'b0, m1_ack, m0_ack}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
